regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 118 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter for two writeback requesters onto one
// register file write port, with a sequential zero-sweep of registers 1..NREG-1.
`default_nettype none

module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_start,
  output logic              clr_busy,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              last_grant
);

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREG - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
  logic                last_grant_q, last_grant_d;

  logic                arb_open;
  logic                a_xfer;
  logic                b_xfer;

  // On contention the grant goes to the requester that did not win last time.
  assign arb_open = (state_q == ARB) && !clr_start;
  assign a_ready  = arb_open && a_valid && (!b_valid || last_grant_q);
  assign b_ready  = arb_open && b_valid && (!a_valid || !last_grant_q);
  assign a_xfer   = a_valid && a_ready;
  assign b_xfer   = b_valid && b_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rf_we_d      = 1'b0;
    rf_addr_d    = rf_addr_q;
    rf_wdata_d   = rf_wdata_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ARB: begin
        if (clr_start) begin
          state_d = CLEAR;
          cnt_d   = ADDR_W'(1);
        end else if (a_xfer) begin
          rf_we_d      = (a_addr != '0);
          rf_addr_d    = a_addr;
          rf_wdata_d   = a_data;
          last_grant_d = 1'b0;
        end else if (b_xfer) begin
          rf_we_d      = (b_addr != '0);
          rf_addr_d    = b_addr;
          rf_wdata_d   = b_data;
          last_grant_d = 1'b1;
        end
      end
      CLEAR: begin
        rf_we_d    = 1'b1;
        rf_addr_d  = cnt_q;
        rf_wdata_d = '0;
        if (cnt_q == LAST_IDX) begin
          state_d = ARB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB;
      cnt_q        <= '0;
      rf_we_q      <= 1'b0;
      rf_addr_q    <= '0;
      rf_wdata_q   <= '0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rf_we_q      <= rf_we_d;
      rf_addr_q    <= rf_addr_d;
      rf_wdata_q   <= rf_wdata_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign clr_busy   = (state_q == CLEAR);
  assign rf_we      = rf_we_q;
  assign rf_addr    = rf_addr_q;
  assign rf_wdata   = rf_wdata_q;
  assign last_grant = last_grant_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (default parameters).
`default_nettype none

module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_start;
  logic        clr_busy;
  logic        a_valid, a_ready;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        b_valid, b_ready;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic        last_grant;

  int checks = 0;
  int errors = 0;
  int busy_cycles;

  regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .NREG(32)) dut (
    .clk(clk), .rst(rst), .clr_start(clr_start), .clr_busy(clr_busy),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .last_grant(last_grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle so registered outputs can be sampled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; clr_start = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    step(); step();
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_addr", rf_addr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_clr_busy", clr_busy, 0);
    chk("rst_last_grant", last_grant, 1);
    rst = 1'b0;

    // Single requester A
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h6; #1;
    chk("a_alone_ready", a_ready, 1);
    chk("a_alone_b_ready", b_ready, 0);
    step(); a_valid = 1'b0;
    chk("a_alone_we", rf_we, 1);
    chk("a_alone_addr", rf_addr, 5);
    chk("a_alone_data", rf_wdata, 32'h6);
    chk("a_alone_lg", last_grant, 0);
    step();
    chk("idle_we", rf_we, 0);
    chk("idle_addr_hold", rf_addr, 5);
    chk("idle_data_hold", rf_wdata, 32'h6);

    // B writes x0: transfer happens, but no register write
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hFFFF_FFFF; #1;
    chk("b_x0_ready", b_ready, 1);
    step(); b_valid = 1'b0;
    chk("b_x0_we", rf_we, 0);
    chk("b_x0_lg", last_grant, 1);

    // Contention: round-robin A,B,A,B
    a_valid = 1'b1; a_addr = 5'd6; a_data = 32'hA;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'hB;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_a_ready", a_ready, (i % 2 == 0) ? 1 : 0);
      chk("rr_b_ready", b_ready, (i % 2 == 0) ? 0 : 1);
      step();
      chk("rr_we", rf_we, 1);
      chk("rr_addr", rf_addr, (i % 2 == 0) ? 6 : 7);
      chk("rr_data", rf_wdata, (i % 2 == 0) ? 32'hA : 32'hB);
      chk("rr_lg", last_grant, (i % 2 == 0) ? 0 : 1);
    end
    b_valid = 1'b0;

    // Clear sweep with A pending; a second clr_start mid-sweep is ignored
    a_addr = 5'd9; a_data = 32'h99; clr_start = 1'b1; #1;
    chk("clr_start_a_ready", a_ready, 0);
    step(); clr_start = 1'b0;
    chk("clr_enter_we", rf_we, 0);
    busy_cycles = 0;
    for (int k = 1; k <= 31; k++) begin
      if (k == 5) clr_start = 1'b1;
      #1;
      if (clr_busy) busy_cycles++;
      chk("clr_a_ready", a_ready, 0);
      step(); clr_start = 1'b0;
      chk("clr_we", rf_we, 1);
      chk("clr_addr", rf_addr, k);
      chk("clr_data", rf_wdata, 0);
    end
    chk("clr_busy_done", clr_busy, 0);
    chk("clr_busy_cycles", busy_cycles, 31);
    chk("post_clr_lg", last_grant, 1);
    chk("post_clr_a_ready", a_ready, 1);
    step(); a_valid = 1'b0;
    chk("post_clr_we", rf_we, 1);
    chk("post_clr_addr", rf_addr, 9);
    chk("post_clr_data", rf_wdata, 32'h99);
    chk("post_clr_lg2", last_grant, 0);

    // Reset aborts a sweep at counter 10 and dominates a concurrent handshake
    clr_start = 1'b1;
    step(); clr_start = 1'b0;
    for (int k = 1; k <= 9; k++) step();
    chk("abort_pre_addr", rf_addr, 9);
    chk("abort_pre_busy", clr_busy, 1);
    rst = 1'b1; a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h33;
    step(); rst = 1'b0; a_valid = 1'b0;
    chk("abort_busy", clr_busy, 0);
    chk("abort_we", rf_we, 0);
    chk("abort_addr", rf_addr, 0);
    chk("abort_lg", last_grant, 1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("abort_no_write", rf_we, 0);
      chk("abort_idle_busy", clr_busy, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
